// File: rtl/pixel_frame_buffer.sv
// Double-buffered RGB pixel store for a HUB75 scan controller.
// Host fills the back bank; the bank swap waits for a frame boundary.
module pixel_frame_buffer #(
    parameter int COLS = 32,
    parameter int ROWS = 16,
    parameter int CDEPTH = 8,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS),
    localparam int PW = 3 * CDEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CW-1:0]    wr_x,
    input  logic [RW:0]      wr_y,
    input  logic [PW-1:0]    wr_rgb,
    input  logic             swap_req,
    output logic             swap_ack,
    input  logic             frame_end,
    input  logic             rd_en,
    input  logic [RW+CW-1:0] rd_addr,
    input  logic [8:0]       pwm_ctr,
    output logic [2:0]       rgb1,
    output logic [2:0]       rgb2,
    output logic             front_bank
);
    localparam int AW = RW + CW;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        state_q, state_d;
    logic          front_bank_q, front_bank_d;
    logic          wr_ready_q, wr_ready_d;
    logic          swap_ack_q, swap_ack_d;
    logic [PW-1:0] top_q, top_d;
    logic [PW-1:0] bot_q, bot_d;
    logic [8:0]    pwm_q, pwm_d;
    logic          rd_v_q, rd_v_d;
    logic [2:0]    rgb1_q, rgb1_d;
    logic [2:0]    rgb2_q, rgb2_d;

    // Flat storage indexed {bank, half, row, col}
    logic [PW-1:0] mem [2**(AW+2)];
    logic [AW+1:0] wr_idx, top_idx, bot_idx;
    logic          wr_fire;

    assign wr_fire = wr_valid && wr_ready_q;
    assign wr_idx  = {~front_bank_q, wr_y, wr_x};
    assign top_idx = {front_bank_q, 1'b0, rd_addr};
    assign bot_idx = {front_bank_q, 1'b1, rd_addr};

    function automatic logic [2:0] shade(input logic [PW-1:0] w,
                                         input logic [8:0] pwm);
        logic [2:0] b;
        b = '0;
        for (int c = 0; c < 3; c++) begin
            b[c] = 9'(w[(2-c)*CDEPTH +: CDEPTH]) > pwm;
        end
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_idx] <= wr_rgb;
        end
    end

    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        swap_ack_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    state_d      = IDLE;
                    front_bank_d = ~front_bank_q;
                    swap_ack_d   = 1'b1;
                end
            end
        endcase
        wr_ready_d = (state_d == IDLE);
    end

    // Stage 1 captures both halves; stage 2 applies the PWM compare
    always_comb begin
        top_d  = top_q;
        bot_d  = bot_q;
        pwm_d  = pwm_q;
        rd_v_d = rd_en;
        rgb1_d = rgb1_q;
        rgb2_d = rgb2_q;
        if (rd_en) begin
            top_d = mem[top_idx];
            bot_d = mem[bot_idx];
            pwm_d = pwm_ctr;
        end
        if (rd_v_q) begin
            rgb1_d = shade(top_q, pwm_q);
            rgb2_d = shade(bot_q, pwm_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            front_bank_q <= 1'b0;
            wr_ready_q   <= 1'b0;
            swap_ack_q   <= 1'b0;
            top_q        <= '0;
            bot_q        <= '0;
            pwm_q        <= '0;
            rd_v_q       <= 1'b0;
            rgb1_q       <= '0;
            rgb2_q       <= '0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            wr_ready_q   <= wr_ready_d;
            swap_ack_q   <= swap_ack_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            pwm_q        <= pwm_d;
            rd_v_q       <= rd_v_d;
            rgb1_q       <= rgb1_d;
            rgb2_q       <= rgb2_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign swap_ack   = swap_ack_q;
    assign front_bank = front_bank_q;
    assign rgb1       = rgb1_q;
    assign rgb2       = rgb2_q;
endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
- Double-buffered pixel store feeding the HUB75 display controller.
- A host writes 24-bit RGB pixels into the back bank. The controller reads the front bank with its {row, col} address counter and current PWM count, and the block returns the 1-bit-per-channel rgb1 (top half) and rgb2 (bottom half) line data.
- Bank swap is deferred to a frame boundary, so a frame being scanned out never tears.

Parameters:
- COLS, 32, pixels per row (power of 2); column index width CW = log2(COLS) = 5.
- ROWS, 16, row addresses per half-panel; the panel is 2*ROWS lines; RW = log2(ROWS) = 4.
- CDEPTH, 8, bits per colour channel.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  block can accept a write.
- wr_x  in  CW  pixel column, 0..COLS-1.
- wr_y  in  RW+1  pixel line, 0..2*ROWS-1; MSB selects the bottom half.
- wr_rgb  in  3*CDEPTH  pixel data: R=[23:16], G=[15:8], B=[7:0].
- swap_req  in  1  one-cycle pulse: back bank complete.
- swap_ack  out  1  one-cycle pulse: swap executed.
- frame_end  in  1  one-cycle pulse from the controller at row wrap (end of a frame).
- rd_en  in  1  read strobe.
- rd_addr  in  RW+CW  {row[8:5], col[4:0]} from the controller address counter.
- pwm_ctr  in  9  controller PWM count, 0..256.
- rgb1  out  3  top-half bits: [0]=R, [1]=G, [2]=B.
- rgb2  out  3  bottom-half bits, same ordering.
- front_bank  out  1  bank currently displayed.

Behaviour:
- Storage:
  - 2 banks x 2 halves, each an array of ROWS*COLS words of 3*CDEPTH bits.
  - The half is selected by wr_y[RW]; the word index is {wr_y[RW-1:0], wr_x}.
  - RAM contents are not reset.
- Reset (async, rst high): wr_ready=0 while rst is asserted and 1 on the first clock after release; swap_ack=0; rgb1=rgb2=0; front_bank=0; swap_pending=0; read pipeline valid flags cleared.
- Write:
  - A write is accepted on a rising edge with wr_valid && wr_ready. The pixel goes to bank ~front_bank.
  - wr_ready = !swap_pending (registered).
  - wr_valid while wr_ready=0 is ignored, with no side effects.
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req -> PENDING, swap_pending=1, wr_ready=0 from the next cycle.
  - PENDING: on the first frame_end seen in PENDING:
    - front_bank toggles;
    - swap_ack=1 for exactly one cycle;
    - return to IDLE;
    - wr_ready=1 from the next cycle.
  - A frame_end arriving in the same cycle as swap_req does not swap; the swap waits for the next frame_end.
  - swap_req while in PENDING is ignored.
- Read pipeline, fixed 2-cycle latency:
  - Cycle N: rd_en=1. rd_addr is read from both halves of front_bank as sampled at N; pwm_ctr is registered alongside.
  - Cycle N+1: the two 24-bit words and pwm_ctr are available.
  - Cycle N+2: rgb1/rgb2 are registered outputs. Bit c = ({1'b0, chan_c} > pwm_ctr) as a 9-bit unsigned compare.
    - Channel 0 is always off.
    - Channel 255 is on for pwm_ctr 0..254 and off at 255 and 256.
  - rd_en=0: outputs hold their last value.
  - A swap between N and N+2 does not affect an in-flight read.
- Write/read collision: a same-cycle write to the front bank cannot occur, since writes always target the back bank. A read of the back bank is never issued.
- Reset mid-operation:
  - A pending swap is cancelled and front_bank returns to 0.
  - In-flight reads are discarded; outputs are 0 until the next rd_en completes.

Test Plan:
- Reset: assert rst mid-run -> rgb1=rgb2=0, swap_ack=0, front_bank=0, wr_ready=0 while rst is asserted; wr_ready=1 on the first clock after release.
- Basic path: write x=3, y=2, rgb=0x8040FF; pulse swap_req, then frame_end -> swap_ack pulses once, front_bank=1. rd_en with rd_addr={4'd2, 5'd3}, pwm_ctr=127 -> two cycles later rgb1=3'b101.
- Bottom half: write y=18, x=3, rgb=0x00FF00; swap. Read {2, 3} with pwm_ctr=0 -> rgb2=3'b010, rgb1 unaffected by that pixel.
- PWM boundaries: channel value 255 with pwm_ctr 254/255/256 -> 1/0/0. Value 0 with pwm_ctr 0 -> 0. Value 1 with pwm_ctr 0 -> 1.
- Swap handshake:
  - swap_req and frame_end in the same cycle -> no swap.
  - wr_ready=0 with wr_valid held high -> the back bank is unchanged.
  - Next frame_end -> swap_ack single pulse; wr_ready=1 one cycle later.
- Read across swap: rd_en issued one cycle before the swap executes -> the output reflects the old front bank; the following read reflects the new front bank.
